// File: rtl/mpsoc_noc_pkg.sv
// Shared NoC definitions: flit record and sizing helpers for the
// virtual-channel receive buffers.
package mpsoc_noc_pkg;

  // Default link flit payload width.
  localparam int unsigned NOC_FLIT_WIDTH = 32;

  // One buffered link word: payload plus end-of-packet marker.
  typedef struct packed {
    logic                      last;
    logic [NOC_FLIT_WIDTH-1:0] flit;
  } flit_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a storage array of the given depth (depth >= 2).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mpsoc_noc_vc_fifo.sv
// Single virtual-channel FIFO. Ready is a function of occupancy only, so the
// upstream arbiter never sees a combinational path from the downstream ready.
// Pointers wrap by explicit compare so non-power-of-two depths work.
module mpsoc_noc_vc_fifo
  import mpsoc_noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_req,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned CNT_W = count_width(BUFFER_DEPTH);
  localparam int unsigned PTR_W = ptr_width(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);

  logic [FLIT_WIDTH:0] mem_q [BUFFER_DEPTH];
  logic [FLIT_WIDTH:0] mem_d [BUFFER_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready is held low throughout reset, even before the counters clear.
  assign in_ready  = !rst && (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = push_req && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_last, out_flit} = mem_q[rd_ptr_q];

  // Write the incoming word into the slot at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_last, in_flit};
    end
  end

  // Pointer advance and occupancy update; simultaneous push/pop keeps count.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is intentionally not reset; the cleared count hides stale words.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control state with synchronous reset; reset drops any buffered packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mpsoc_noc_vchannel_demux_buffer.sv
// Receive side of a virtual-channel multiplexed link: steers the shared flit
// bus into one FIFO per VC and flags cycles where more than one VC valid is set.
module mpsoc_noc_vchannel_demux_buffer
  import mpsoc_noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH   = 32,
  parameter int unsigned CHANNELS     = 7,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FLIT_WIDTH-1:0]          in_flit,
  input  logic                           in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
  output logic [CHANNELS-1:0]            out_last,
  output logic [CHANNELS-1:0]            out_valid,
  input  logic [CHANNELS-1:0]            out_ready,
  output logic                           err_multi
);

  logic onehot_ok;
  logic err_multi_q, err_multi_d;

  // A malformed valid vector must not write any VC, so gate every push with it.
  assign onehot_ok = $onehot0(in_valid);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    mpsoc_noc_vc_fifo #(
      .FLIT_WIDTH  (FLIT_WIDTH),
      .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_req (in_valid[c] && onehot_ok),
      .in_flit  (in_flit),
      .in_last  (in_last),
      .in_ready (in_ready[c]),
      .out_flit (out_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
      .out_last (out_last[c]),
      .out_valid(out_valid[c]),
      .out_ready(out_ready[c])
    );
  end

  // Violation seen this cycle becomes a one-cycle error pulse next cycle.
  always_comb begin
    err_multi_d = !onehot_ok;
  end

  // Error flag register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_q <= 1'b0;
    end else begin
      err_multi_q <= err_multi_d;
    end
  end

  assign err_multi = err_multi_q;

endmodule

// File: tb/tb_mpsoc_noc_vchannel_demux_buffer.sv
// Scoreboard bench for the VC demux buffer: a per-VC queue model predicts
// ready/valid/error and the popped flit stream under directed and random traffic.
module tb_mpsoc_noc_vchannel_demux_buffer;
  import mpsoc_noc_pkg::*;

  localparam int CH = 7;
  localparam int FW = 32;
  localparam int D  = 4;

  logic            clk;
  logic            rst;
  logic [FW-1:0]   in_flit;
  logic            in_last;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [CH*FW-1:0] out_flit;
  logic [CH-1:0]   out_last;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready;
  logic            err_multi;

  int tests = 0;
  int fails = 0;

  flit_t sb_q [CH][$];
  logic  exp_err;
  logic [2:0] dut_cnt [CH];

  mpsoc_noc_vchannel_demux_buffer #(
    .FLIT_WIDTH  (FW),
    .CHANNELS    (CH),
    .BUFFER_DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_flit  (in_flit),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_flit (out_flit),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_multi(err_multi)
  );

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign dut_cnt[g] = dut.g_vc[g].u_fifo.count_q;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int vc, input logic [FW-1:0] f, input logic l);
    in_valid = CH'(1 << vc);
    in_flit  = f;
    in_last  = l;
    cyc();
    in_valid = '0;
  endtask

  // Reference model / monitor: evaluated mid-cycle, it represents the state
  // the DUT holds now and applies the coming edge's pushes, pops and resets.
  initial begin
    logic [CH-1:0] exp_rdy;
    logic [CH-1:0] exp_vld;
    logic          onehot;
    exp_err = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        exp_rdy[c] = !rst && (sb_q[c].size() != D);
        exp_vld[c] = (sb_q[c].size() != 0);
      end
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      check("err_multi", 64'(err_multi), 64'(exp_err));
      for (int c = 0; c < CH; c++) begin
        check("count_bound", 64'(dut_cnt[c] <= 3'(D)), 64'd1);
        check("count_model", 64'(dut_cnt[c]), 64'(sb_q[c].size()));
      end
      onehot = ($countones(in_valid) <= 1);
      if (rst) begin
        exp_err = 1'b0;
        for (int c = 0; c < CH; c++) sb_q[c].delete();
      end else begin
        exp_err = !onehot;
        for (int c = 0; c < CH; c++) begin
          if (exp_vld[c] && out_ready[c]) begin
            check("pop_flit", 64'({out_last[c], out_flit[c*FW +: FW]}), 64'(sb_q[c][0]));
            void'(sb_q[c].pop_front());
          end
          if (in_valid[c] && exp_rdy[c] && onehot) begin
            sb_q[c].push_back(flit_t'({in_last, in_flit}));
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int total;
    rst       = 1'b1;
    in_flit   = '0;
    in_last   = 1'b0;
    in_valid  = '0;
    out_ready = '0;

    // Reset / idle
    repeat (3) begin
      cyc();
      check("rst_in_ready", 64'(in_ready), 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h7F);
    check("post_rst_out_valid", 64'(out_valid), 64'h0);
    check("post_rst_err", 64'(err_multi), 64'h0);

    // Single VC latency
    push1(2, 32'hA5A5_0001, 1'b1);
    check("lat_out_valid", 64'(out_valid), 64'h04);
    check("lat_out_flit", 64'(out_flit[2*FW +: FW]), 64'hA5A5_0001);
    check("lat_out_last", 64'(out_last[2]), 64'h1);
    out_ready = 7'h04;
    cyc();
    out_ready = '0;
    check("lat_pop_valid", 64'(out_valid), 64'h0);

    // Fill and wrap on VC 0
    for (int i = 1; i <= 4; i++) push1(0, 32'(i), (i % 2) == 0);
    check("fill_ready0", 64'(in_ready[0]), 64'h0);
    push1(0, 32'h99, 1'b1);
    check("fill_ignored_cnt", 64'(dut_cnt[0]), 64'd4);
    out_ready = 7'h01;
    cyc();
    out_ready = '0;
    check("fill_ready_after_pop", 64'(in_ready[0]), 64'h1);
    push1(0, 32'd5, 1'b1);
    out_ready = 7'h01;
    repeat (5) cyc();
    out_ready = '0;

    // Simultaneous push/pop on VC 3 across pointer wrap
    push1(3, 32'h30, 1'b0);
    push1(3, 32'h31, 1'b1);
    for (int i = 0; i < 6; i++) begin
      in_valid  = 7'h08;
      in_flit   = 32'h40 + 32'(i);
      in_last   = i[0];
      out_ready = 7'h08;
      cyc();
      check("vc3_count_steady", 64'(dut_cnt[3]), 64'd2);
    end
    in_valid  = '0;
    out_ready = '0;
    push1(3, 32'h50, 1'b0);
    push1(3, 32'h51, 1'b1);
    in_valid  = 7'h08;
    in_flit   = 32'h5F;
    out_ready = 7'h08;
    check("vc3_full_ready", 64'(in_ready[3]), 64'h0);
    cyc();
    in_valid  = '0;
    out_ready = '0;
    check("vc3_freed_ready", 64'(in_ready[3]), 64'h1);
    check("vc3_after_cnt", 64'(dut_cnt[3]), 64'd3);
    out_ready = 7'h08;
    repeat (4) cyc();
    out_ready = '0;

    // Independence: VC 1 stalled full, VC 5 streaming
    for (int i = 0; i < 4; i++) push1(1, 32'h100 + 32'(i), i == 3);
    out_ready = 7'h20;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i % 2 == 1) ? 7'h02 : 7'h20;
      in_flit  = 32'h500 + 32'(i);
      in_last  = (i % 4 == 0);
      cyc();
    end
    in_valid = '0;
    check("indep_vc1_cnt", 64'(dut_cnt[1]), 64'd4);
    out_ready = 7'h22;
    repeat (6) cyc();
    out_ready = '0;

    // Protocol violation
    push1(1, 32'hE1, 1'b0);
    in_valid = 7'h06;
    in_flit  = 32'hBAD;
    cyc();
    in_valid = '0;
    check("viol_err_set", 64'(err_multi), 64'h1);
    check("viol_cnt1", 64'(dut_cnt[1]), 64'd1);
    check("viol_cnt2", 64'(dut_cnt[2]), 64'd0);
    cyc();
    check("viol_err_clear", 64'(err_multi), 64'h0);
    out_ready = '1;
    repeat (2) cyc();
    out_ready = '0;

    // Reset mid-packet
    for (int i = 0; i < 3; i++) push1(4, 32'h400 + 32'(i), i == 2);
    check("rst_vc4_pre", 64'(out_valid[4]), 64'h1);
    rst = 1'b1;
    cyc();
    check("rst_vc4_post", 64'(out_valid[4]), 64'h0);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int sel;
      sel = $urandom_range(0, 39);
      if (sel < 32) begin
        in_valid = CH'(1 << (sel % CH));
      end else if (sel < 38) begin
        in_valid = '0;
      end else begin
        int a, b;
        a = $urandom_range(0, CH - 1);
        b = (a + $urandom_range(1, CH - 1)) % CH;
        in_valid = CH'((1 << a) | (1 << b));
      end
      in_flit   = $urandom;
      in_last   = $urandom_range(0, 1) == 1;
      out_ready = CH'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    repeat (8) cyc();
    @(negedge clk);
    #1;
    total = 0;
    for (int c = 0; c < CH; c++) total += sb_q[c].size();
    check("final_drain", 64'(total), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mpsoc_noc_vchannel_demux_buffer.md
Name: mpsoc_noc_vchannel_demux_buffer

Overview:
- Receive side of a physical link shared by CHANNELS virtual channels.
- Consumes the single flit bus plus per-channel valid produced by the virtual-channel mux at the link source.
- Steers each flit into a per-VC FIFO and presents independent per-VC flit streams to the downstream router input stage.
- Per-VC ready is derived only from buffer occupancy, so the upstream arbiter sees credit-like backpressure with no combinational path from the downstream ready inputs.

Parameters:
- FLIT_WIDTH, 32, flit payload width in bits.
- CHANNELS, 7, number of virtual channels; must be at least 1.
- BUFFER_DEPTH, 4, flits stored per VC; must be at least 2; any value allowed, power of two not required.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_flit  input  FLIT_WIDTH  shared link flit.
- in_last  input  1  flit is the last flit of its packet.
- in_valid  input  CHANNELS  one-hot or zero; the set bit names the VC carrying in_flit.
- in_ready  output  CHANNELS  VC c can accept a flit this cycle.
- out_flit  output  CHANNELS x FLIT_WIDTH  head flit of each VC FIFO.
- out_last  output  CHANNELS  last flag of each head flit.
- out_valid  output  CHANNELS  VC FIFO non-empty.
- out_ready  input  CHANNELS  downstream pops the head of VC c.
- err_multi  output  1  registered pulse: a protocol violation was seen in the previous cycle.

Behaviour:
- Per VC c, state is: storage[BUFFER_DEPTH] of {last, flit}, rd_ptr, wr_ptr, and count. count is $clog2(BUFFER_DEPTH+1) bits wide.
- Reset:
  - All counts and pointers are 0; storage is not cleared.
  - out_valid = 0 and err_multi = 0.
  - in_ready is forced to 0 for every cycle that rst is high.
  - A reset asserted mid-packet discards all buffered flits. No partial packet survives reset.
- in_ready[c] = !rst && (count[c] != BUFFER_DEPTH). It depends only on registered state.
- Push[c] = in_valid[c] & in_ready[c] & onehot_ok. On a push, {in_last, in_flit} is written at wr_ptr[c].
- onehot_ok = $onehot0(in_valid).
  - If two or more bits are set: nothing is written on any VC.
  - err_multi is 1 in the following cycle, for one cycle.
  - FIFO state is otherwise unaffected.
- Pop[c] = out_valid[c] & out_ready[c].
- out_valid[c] = (count[c] != 0). out_flit[c] and out_last[c] = storage[rd_ptr[c]].
- out_flit and out_last are don't-care when out_valid is 0.
- Latency: a flit pushed at edge N is visible on out_* after edge N, so it can be popped in the cycle following the push. There is no same-cycle bypass.
- Simultaneous push and pop on the same VC:
  - Both pointers advance and count is unchanged.
  - When full (count == BUFFER_DEPTH), push is blocked because in_ready is 0, even if a pop happens in the same cycle. The freed slot shows on in_ready after the edge.
  - When empty, the pop is not possible because out_valid is 0. The push proceeds.
- Pointer wrap: a pointer equal to BUFFER_DEPTH-1 becomes 0 when it advances. Explicit compare is used, not modulo, so any depth works.
- VCs are fully independent: backpressure on one VC never stalls another VC.
- Order is preserved within a VC. in_last is stored and passed through unmodified; the block does no packet reassembly.
- in_valid on a VC whose in_ready is 0 is ignored (no push), with no error.
- Counts never exceed BUFFER_DEPTH and never go below 0. Assertions in the bench check both bounds.

Decomposition:
- Shared package mpsoc_noc_pkg holds:
  - typedef flit_t, the {last, flit} record of FLIT_WIDTH+1 bits;
  - a helper constant function for the count width.
- One natural sub-module: mpsoc_noc_vc_fifo (single-VC synchronous FIFO with push/pop/count, parameterised by FLIT_WIDTH and BUFFER_DEPTH).
- The top instantiates CHANNELS copies in a generate loop and adds the onehot check and err_multi register.

Test Plan:
- Reset/idle:
  - Hold rst 3 cycles -> in_ready = 0 and out_valid = 0 throughout.
  - First cycle after rst falls -> in_ready = 7'h7F, out_valid = 0, err_multi = 0.
- Single VC latency:
  - Push flit 32'hA5A5_0001 with last = 1 on VC 2 at edge N.
  - Required: out_valid = 7'h04 after edge N, out_flit[2] = 32'hA5A5_0001, out_last[2] = 1.
  - Pop at edge N+1 -> out_valid = 0.
- Fill and wrap, depth 4, out_ready[0] = 0:
  - Push 1, 2, 3, 4 on VC 0 -> in_ready[0] = 0 after the 4th push.
  - A 5th valid is ignored.
  - Pop one -> in_ready[0] = 1 after the pop edge; push 5.
  - Pop all -> sequence 2, 3, 4, 5 with correct last flags.
- Simultaneous push and pop on VC 3 at count 2 -> count stays 2 and order is preserved across the pointer wrap.
  - While full, push+pop in the same cycle -> push rejected (in_ready[3] = 0 that cycle).
- Independence:
  - VC 1 full and stalled (out_ready[1] = 0); interleave pushes to VC 1 and VC 5.
  - Required: all VC 5 flits pass at full rate, and VC 1 pushes stall with no loss.
- Violation:
  - in_valid = 7'h06 for one cycle -> no FIFO count changes; err_multi = 1 for exactly the next cycle.
  - Reset asserted with 3 flits buffered on VC 4 -> out_valid[4] = 0 after the reset edge.
